reg_grp_ctrl: RTL and testbench

Register-bus splitter and sequencer between one upstream register interface and NUM_SLAVES downstream register blocks. It decodes the upper address bits, forwards one transaction at a time to the selected block, waits for that block's ack, and returns the read data upstream. Unmapped indices and unresponsive blocks are terminated locally with read data 0xDEAD_BEEF, so the host bus never hangs.

---
 rtl/reg_grp_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_reg_grp_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_grp_ctrl.sv
// -----------------------------------------------------------------------------
// reg_grp_ctrl
//
// Splits one upstream register bus across NUM_SLAVES downstream register
// blocks. The upper address bits select the block. Exactly one transaction is
// in flight at a time: it is forwarded to the selected block, the controller
// waits for that block's ack, and the captured read data is returned upstream
// with a one-cycle reg_ack_o pulse.
//
// Two cases are completed locally with read data 0xDEAD_BEEF, so the host
// never hangs:
//   - the index is unmapped (idx >= NUM_SLAVES);
//   - the selected block has not acked after TIMEOUT cycles. timeout_err_o
//     pulses together with reg_ack_o in this case.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   reg_req_i             upstream request, held until reg_ack_o is seen
//   reg_ack_o             one-cycle completion pulse
//   reg_rd_wr_l_i         1 = read, 0 = write
//   reg_addr_i            upstream address {idx, slave address}
//   reg_wr_data_i         upstream write data
//   reg_rd_data_o         read data; valid with reg_ack_o, held until the next
//                         completion
//   slv_reg_req_o         per-slave request, one-hot or zero
//   slv_reg_ack_i         per-slave ack pulses
//   slv_reg_rd_wr_l_o     per-slave rd/wr strobe (all bits identical)
//   slv_reg_addr_o        per-slave address, slice i for slave i (all identical)
//   slv_reg_wr_data_o     per-slave write data, slice i for slave i (identical)
//   slv_reg_rd_data_i     per-slave read data, slice i from slave i
//   timeout_err_o         pulses with a reg_ack_o caused by a timeout
//
// Every output is driven directly from a register.
// -----------------------------------------------------------------------------
module reg_grp_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 7,
  parameter int unsigned SLV_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SLAVES     = 3,
  // Range 2..255.
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  // Upstream register interface
  input  logic                               reg_req_i,
  output logic                               reg_ack_o,
  input  logic                               reg_rd_wr_l_i,
  input  logic [REG_ADDR_WIDTH-1:0]          reg_addr_i,
  input  logic [DATA_WIDTH-1:0]              reg_wr_data_i,
  output logic [DATA_WIDTH-1:0]              reg_rd_data_o,

  // Downstream register interfaces
  output logic [NUM_SLAVES-1:0]              slv_reg_req_o,
  input  logic [NUM_SLAVES-1:0]              slv_reg_ack_i,
  output logic [NUM_SLAVES-1:0]              slv_reg_rd_wr_l_o,
  output logic [NUM_SLAVES*SLV_ADDR_WIDTH-1:0] slv_reg_addr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]   slv_reg_wr_data_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   slv_reg_rd_data_i,

  output logic                               timeout_err_o
);

  localparam int unsigned IdxWidth = REG_ADDR_WIDTH - SLV_ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(32'hDEAD_BEEF);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,     // waiting for a new request
    StFwd,      // request forwarded, waiting for the selected block's ack
    StMiss,     // unmapped index, local termination
    StAck,      // reg_ack_o high this cycle
    StWaitRel   // waiting for the host to drop reg_req_i
  } state_e;

  state_e                     state_q;
  logic [IdxWidth-1:0]        idx_q;
  logic [SLV_ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]      wr_data_q;
  logic [DATA_WIDTH-1:0]      rd_data_q;
  logic                       rd_wr_l_q;
  logic                       ack_q;
  logic                       tmo_q;
  logic [NUM_SLAVES-1:0]      slv_req_q;
  logic [7:0]                 cnt_q;

  // ---------------------------------------------------------------------------
  // Decode of the incoming request and selection of the active block's
  // ack/read data.
  // ---------------------------------------------------------------------------
  logic [IdxWidth-1:0]   req_idx;
  logic                  req_mapped;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  sel_ack;
  logic [DATA_WIDTH-1:0] sel_rd_data;

  assign req_idx    = reg_addr_i[REG_ADDR_WIDTH-1:SLV_ADDR_WIDTH];
  assign req_mapped = 32'(req_idx) < NUM_SLAVES;

  always_comb begin
    req_onehot  = '0;
    sel_ack     = 1'b0;
    sel_rd_data = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (req_idx == IdxWidth'(i)) begin
        req_onehot[i] = 1'b1;
      end
      // Only the latched index is listened to; acks from other blocks are
      // dropped.
      if (idx_q == IdxWidth'(i)) begin
        sel_ack     = slv_reg_ack_i[i];
        sel_rd_data = slv_reg_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      rd_wr_l_q <= 1'b0;
      ack_q     <= 1'b0;
      tmo_q     <= 1'b0;
      slv_req_q <= '0;
      cnt_q     <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      ack_q <= 1'b0;
      tmo_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (reg_req_i) begin
            idx_q     <= req_idx;
            addr_q    <= reg_addr_i[SLV_ADDR_WIDTH-1:0];
            wr_data_q <= reg_wr_data_i;
            rd_wr_l_q <= reg_rd_wr_l_i;
            cnt_q     <= '0;
            if (req_mapped) begin
              slv_req_q <= req_onehot;
              state_q   <= StFwd;
            end else begin
              state_q   <= StMiss;
            end
          end
        end

        StFwd: begin
          if (!reg_req_i) begin
            // Host aborted: withdraw quietly, no completion.
            slv_req_q <= '0;
            state_q   <= StIdle;
          end else if (sel_ack) begin
            // Checked before the timeout so a last-cycle ack still wins.
            rd_data_q <= sel_rd_data;
            slv_req_q <= '0;
            ack_q     <= 1'b1;
            state_q   <= StAck;
          end else if (cnt_q == TimeoutLast) begin
            // cnt_q reaches TIMEOUT-1 in the TIMEOUT-th cycle of the request.
            rd_data_q <= ErrData;
            slv_req_q <= '0;
            ack_q     <= 1'b1;
            tmo_q     <= 1'b1;
            state_q   <= StAck;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StMiss: begin
          // One dead cycle keeps unmapped completions at a fixed latency of 2.
          rd_data_q <= ErrData;
          ack_q     <= 1'b1;
          state_q   <= StAck;
        end

        StAck: begin
          state_q <= StWaitRel;
        end

        StWaitRel: begin
          // A request still held high here is the one just completed.
          if (!reg_req_i) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign reg_ack_o         = ack_q;
  assign reg_rd_data_o     = rd_data_q;
  assign timeout_err_o     = tmo_q;
  assign slv_reg_req_o     = slv_req_q;
  assign slv_reg_rd_wr_l_o = {NUM_SLAVES{rd_wr_l_q}};
  assign slv_reg_addr_o    = {NUM_SLAVES{addr_q}};
  assign slv_reg_wr_data_o = {NUM_SLAVES{wr_data_q}};

endmodule

// File: tb/tb_reg_grp_ctrl.sv
module tb_reg_grp_ctrl;

  localparam int RAW = 7;
  localparam int SAW = 5;
  localparam int NS  = 3;
  localparam int TO  = 16;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_req;
  logic              reg_ack;
  logic              reg_rd_wr_l;
  logic [RAW-1:0]    reg_addr;
  logic [DW-1:0]     reg_wr_data;
  logic [DW-1:0]     reg_rd_data;
  logic [NS-1:0]     slv_reg_req;
  logic [NS-1:0]     slv_reg_ack;
  logic [NS-1:0]     slv_reg_rd_wr_l;
  logic [NS*SAW-1:0] slv_reg_addr;
  logic [NS*DW-1:0]  slv_reg_wr_data;
  logic [NS*DW-1:0]  slv_reg_rd_data;
  logic              timeout_err;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev_rd = 32'h0;

  always #5 clk = ~clk;

  reg_grp_ctrl #(
    .REG_ADDR_WIDTH(RAW),
    .SLV_ADDR_WIDTH(SAW),
    .NUM_SLAVES    (NS),
    .TIMEOUT       (TO),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .reg_req_i        (reg_req),
    .reg_ack_o        (reg_ack),
    .reg_rd_wr_l_i    (reg_rd_wr_l),
    .reg_addr_i       (reg_addr),
    .reg_wr_data_i    (reg_wr_data),
    .reg_rd_data_o    (reg_rd_data),
    .slv_reg_req_o    (slv_reg_req),
    .slv_reg_ack_i    (slv_reg_ack),
    .slv_reg_rd_wr_l_o(slv_reg_rd_wr_l),
    .slv_reg_addr_o   (slv_reg_addr),
    .slv_reg_wr_data_o(slv_reg_wr_data),
    .slv_reg_rd_data_i(slv_reg_rd_data),
    .timeout_err_o    (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One host transaction against a behavioural slave. Cycle 0 is the cycle in
  // which reg_req is raised. The selected slave acks in cycle lat+1 (lat cycles
  // after its request first appears) unless that is past the timeout window.
  // Expected timing follows from the rules: request visible cycles 1..end,
  // completion one cycle after the ack (or after the TIMEOUT-th request cycle),
  // unmapped completions in cycle 2.
  task automatic txn(input logic [RAW-1:0] addr, input logic rw, input logic [31:0] wd,
                     input int lat, input logic [31:0] rd, input int hold, input bit spur);
    int          idx;
    bit          mapped;
    bit          acks;
    int          ack_cyc;
    int          req_end;
    logic [31:0] new_rd;
    logic [NS-1:0] onehot;
    logic [NS-1:0] other;
    logic [RAW-1:0] a;

    a       = addr;
    idx     = int'(a[RAW-1:SAW]);
    mapped  = idx < NS;
    acks    = mapped && (lat <= TO - 1);
    ack_cyc = !mapped ? 2 : (acks ? lat + 2 : TO + 1);
    req_end = !mapped ? 0 : (acks ? lat + 1 : TO);
    new_rd  = acks ? rd : 32'hDEAD_BEEF;
    onehot  = mapped ? NS'(1 << idx) : '0;

    reg_req         = 1'b1;
    reg_addr        = addr;
    reg_rd_wr_l     = rw;
    reg_wr_data     = wd;
    slv_reg_ack     = '0;
    slv_reg_rd_data = {$urandom, $urandom, $urandom};

    for (int c = 1; c <= ack_cyc + hold + 1; c++) begin
      step();
      chk("slv_req", 32'(slv_reg_req), (c <= req_end) ? 32'(onehot) : 32'h0);
      chk("reg_ack", 32'(reg_ack), 32'(c == ack_cyc));
      chk("timeout_err", 32'(timeout_err), 32'(c == ack_cyc && mapped && !acks));
      chk("rd_data", reg_rd_data, (c >= ack_cyc) ? new_rd : prev_rd);
      if (c == 1 && mapped) begin
        for (int i = 0; i < NS; i++) begin
          chk("slv_addr", 32'(slv_reg_addr[i*SAW +: SAW]), 32'(a[SAW-1:0]));
          chk("slv_wr_data", slv_reg_wr_data[i*DW +: DW], wd);
          chk("slv_rd_wr_l", 32'(slv_reg_rd_wr_l[i]), 32'(rw));
        end
      end

      // Inputs for cycle c
      reg_req = (c <= ack_cyc + hold);
      other   = spur ? NS'($urandom) : '0;
      if (c <= req_end) begin
        slv_reg_ack = (other & ~onehot) | ((acks && c == lat + 1) ? onehot : '0);
      end else begin
        slv_reg_ack = other;
      end
      slv_reg_rd_data = {$urandom, $urandom, $urandom};
      if (acks && c == lat + 1) slv_reg_rd_data[idx*DW +: DW] = rd;
    end
    step();
    slv_reg_ack = '0;
    chk("idle_ack", 32'(reg_ack), 32'h0);
    prev_rd = new_rd;
  endtask

  initial begin
    reset           = 1'b1;
    reg_req         = 1'b0;
    reg_rd_wr_l     = 1'b0;
    reg_addr        = '0;
    reg_wr_data     = '0;
    slv_reg_ack     = '0;
    slv_reg_rd_data = '0;

    // Reset state
    #2;
    chk("rst_ack", 32'(reg_ack), 32'h0);
    chk("rst_slv_req", 32'(slv_reg_req), 32'h0);
    chk("rst_rd_data", reg_rd_data, 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_slv_addr", 32'(slv_reg_addr), 32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // Mapped read, slave 1 acks two cycles after its request
    txn(7'h25, 1'b1, 32'h0, 2, 32'h1234_5678, 0, 1'b0);
    // Write to slave 0
    txn(7'h03, 1'b0, 32'hA5A5_0001, 1, 32'h0BAD_F00D, 0, 1'b1);
    // Unmapped index 3
    txn(7'h60, 1'b1, 32'h0, 0, 32'h5555_5555, 0, 1'b1);
    // Slave 2 never acks
    txn(7'h4A, 1'b1, 32'h0, TO + 5, 32'h7777_7777, 0, 1'b1);
    // Held request with spurious acks afterwards
    txn(7'h07, 1'b1, 32'h0, 3, 32'hCAFE_0007, 10, 1'b1);
    // Ack in the same cycle the timeout would fire
    txn(7'h41, 1'b1, 32'h0, TO - 1, 32'h0F0F_1234, 1, 1'b1);
    // First-possible-cycle ack
    txn(7'h3F, 1'b0, 32'hFFFF_0000, 0, 32'h8000_0001, 2, 1'b1);

    // Abort: reg_req dropped in cycle 5 while forwarding to slave 2
    reg_req     = 1'b1;
    reg_addr    = 7'h50;
    reg_rd_wr_l = 1'b1;
    slv_reg_ack = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("abort_slv_req", 32'(slv_reg_req), (c <= 5) ? 32'h4 : 32'h0);
      chk("abort_ack", 32'(reg_ack), 32'h0);
      chk("abort_rd_data", reg_rd_data, prev_rd);
      reg_req = (c < 5);
    end
    txn(7'h10, 1'b1, 32'h0, 4, 32'h1357_9BDF, 0, 1'b1);

    // Asynchronous reset in the middle of a forward
    reg_req  = 1'b1;
    reg_addr = 7'h21;
    step();
    step();
    chk("pre_rst_slv_req", 32'(slv_reg_req), 32'h2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_slv_req", 32'(slv_reg_req), 32'h0);
    chk("async_rst_ack", 32'(reg_ack), 32'h0);
    chk("async_rst_rd_data", reg_rd_data, 32'h0);
    reg_req = 1'b0;
    step();
    reset   = 1'b0;
    prev_rd = 32'h0;
    step();
    txn(7'h22, 1'b1, 32'h0, 1, 32'h2468_ACE0, 0, 1'b0);

    // Randomised transactions
    for (int n = 0; n < 40; n++) begin
      txn(RAW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, TO + 3)), $urandom,
          int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
